// File: rtl/master_arbiter_mux.sv
// master_arbiter_mux: arbitrates between NUM_MASTERS requesters and muxes the
// owner's data onto a registered output. It supports round-robin or fixed
// priority, and can preempt an owner that has held the bus too long.
module master_arbiter_mux #(
  parameter int NUM_MASTERS = 4,
  parameter int SEL_BITS    = 2,
  parameter int DATA_WIDTH  = 8,
  parameter int ARB_MODE    = 0,
  parameter int HOLD_LIMIT  = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_MASTERS-1:0]           req,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] data_in,
  output logic [NUM_MASTERS-1:0]           gnt,
  output logic [SEL_BITS-1:0]              sel,
  output logic [DATA_WIDTH-1:0]            data_out,
  output logic                             valid
);

  localparam int HCW = (HOLD_LIMIT > 2) ? $clog2(HOLD_LIMIT) : 1;
  localparam logic [HCW-1:0] HOLD_MAX = (HOLD_LIMIT > 0) ? HCW'(HOLD_LIMIT - 1) : '0;
  localparam logic [SEL_BITS-1:0] LAST_RESET = SEL_BITS'(NUM_MASTERS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arbState_t;

  arbState_t             state;
  arbState_t             nextState;
  logic [NUM_MASTERS-1:0] nextGnt;
  logic [SEL_BITS-1:0]    nextSel;
  logic [SEL_BITS-1:0]    lastOwner;
  logic [HCW-1:0]         holdCnt;
  logic [NUM_MASTERS-1:0] candidates;
  logic                   anyCandidate;
  logic [SEL_BITS-1:0]    winner;
  logic                   ownerReq;
  logic                   holdExpired;
  logic                   newGrant;
  int                     startIdx;
  int                     idx;
  logic [DATA_WIDTH-1:0]  masterData [NUM_MASTERS];

  // Split the flat data bus into one word per master
  always_comb begin
    for (int m = 0; m < NUM_MASTERS; m++) begin
      masterData[m] = data_in[m*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Winner search over every requester except the current owner
  always_comb begin
    candidates   = req & ~gnt;
    anyCandidate = |candidates;
    winner       = '0;
    idx          = 0;
    startIdx     = (ARB_MODE == 1) ? 0 : ((int'(lastOwner) + 1) % NUM_MASTERS);
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      idx = (startIdx + k) % NUM_MASTERS;
      if (candidates[idx]) begin
        winner = SEL_BITS'(idx);
      end
    end
  end

  // Next-state, next-grant and hand-over decision
  always_comb begin
    nextState   = state;
    nextGnt     = gnt;
    nextSel     = sel;
    newGrant    = 1'b0;
    ownerReq    = |(req & gnt);
    holdExpired = (HOLD_LIMIT > 0) && (holdCnt == HOLD_MAX);
    case (state)
      IDLE: begin
        if (anyCandidate) begin
          newGrant = 1'b1;
        end
      end
      GRANT: begin
        if (anyCandidate && (holdExpired || !ownerReq)) begin
          newGrant = 1'b1;
        end else if (!ownerReq) begin
          nextState = IDLE;
          nextGnt   = '0;
          nextSel   = '0;
        end
      end
      default: begin
        nextState = IDLE;
        nextGnt   = '0;
        nextSel   = '0;
      end
    endcase
    if (newGrant) begin
      nextState = GRANT;
      nextGnt   = NUM_MASTERS'(1) << winner;
      nextSel   = winner;
    end
  end

  // Arbitration state, grant, owner history and hold counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      sel       <= '0;
      lastOwner <= LAST_RESET;
      holdCnt   <= '0;
    end else begin
      state <= nextState;
      gnt   <= nextGnt;
      sel   <= nextSel;
      if (newGrant) begin
        lastOwner <= winner;
        holdCnt   <= '0;
      end else if (state == GRANT && holdCnt != HOLD_MAX) begin
        holdCnt <= holdCnt + HCW'(1);
      end
    end
  end

  // Registered data path: capture the owner's word one cycle after the grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
      valid    <= 1'b0;
    end else if (state == GRANT) begin
      data_out <= masterData[sel];
      valid    <= 1'b1;
    end else begin
      valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_master_arbiter_mux.sv
// tb_master_arbiter_mux: drives three arbiter instances (round-robin with
// hold limit 4, fixed priority with hold limit 4, all defaults) from shared
// stimulus and compares each against a bench-side reference model.
module tb_master_arbiter_mux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  reqVec = '0;
  logic [31:0] dataIn = 32'hD4C3_B2A1;

  logic [3:0]  gntA   [3];
  logic [1:0]  selA   [3];
  logic [7:0]  dataA  [3];
  logic        validA [3];

  int checks = 0;
  int errors = 0;

  // Per-instance configuration and model state
  int          modeOf [3] = '{0, 1, 0};
  int          holdOf [3] = '{4, 4, 16};
  int          mOwner [3];
  int          mLast  [3];
  int          mHeld  [3];
  logic [7:0]  mData  [3];
  logic        mValid [3];

  master_arbiter_mux #(.ARB_MODE(0), .HOLD_LIMIT(4)) dutRr (
    .clk(clk), .rst_n(rst_n), .req(reqVec), .data_in(dataIn),
    .gnt(gntA[0]), .sel(selA[0]), .data_out(dataA[0]), .valid(validA[0]));

  master_arbiter_mux #(.ARB_MODE(1), .HOLD_LIMIT(4)) dutFx (
    .clk(clk), .rst_n(rst_n), .req(reqVec), .data_in(dataIn),
    .gnt(gntA[1]), .sel(selA[1]), .data_out(dataA[1]), .valid(validA[1]));

  master_arbiter_mux dutDef (
    .clk(clk), .rst_n(rst_n), .req(reqVec), .data_in(dataIn),
    .gnt(gntA[2]), .sel(selA[2]), .data_out(dataA[2]), .valid(validA[2]));

  // Free-running clock, period 10
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive a request pattern and let the given number of cycles elapse;
  // returns just after a falling edge so outputs are settled.
  task automatic applyStimulus(input logic [3:0] value, input int cycles);
    reqVec = value;
    repeat (cycles) @(negedge clk);
    #1;
  endtask

  // Winner by rule: fixed picks the lowest index, round-robin picks the
  // requester closest after the last owner going upward with wrap.
  function automatic int pickWinner(input int mode, input logic [3:0] cand, input int last);
    int best;
    int bestDist;
    best = -1;
    bestDist = 99;
    for (int i = 0; i < 4; i++) begin
      if (cand[i]) begin
        int d;
        d = (mode == 1) ? i : ((i - last - 1 + 8) % 4);
        if (d < bestDist) begin
          bestDist = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [3:0] ownerMask(input int owner);
    return (owner >= 0) ? (4'b0001 << owner) : 4'b0000;
  endfunction

  // Reference model: advances on each rising edge using pre-edge inputs
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        mOwner[i] = -1;
        mLast[i]  = 3;
        mHeld[i]  = 0;
        mData[i]  = 8'h00;
        mValid[i] = 1'b0;
      end else begin
        logic [3:0] others;
        logic ownerWants;
        if (mOwner[i] >= 0) begin
          mValid[i] = 1'b1;
          mData[i]  = dataIn[mOwner[i]*8 +: 8];
        end else begin
          mValid[i] = 1'b0;
        end
        if (mOwner[i] < 0) begin
          if (reqVec != 4'b0000) begin
            mOwner[i] = pickWinner(modeOf[i], reqVec, mLast[i]);
            mLast[i]  = mOwner[i];
            mHeld[i]  = 0;
          end
        end else begin
          mHeld[i]++;
          others     = reqVec & ~ownerMask(mOwner[i]);
          ownerWants = reqVec[mOwner[i]];
          if (others != 4'b0000 &&
              ((holdOf[i] > 0 && mHeld[i] >= holdOf[i]) || !ownerWants)) begin
            mOwner[i] = pickWinner(modeOf[i], others, mLast[i]);
            mLast[i]  = mOwner[i];
            mHeld[i]  = 0;
          end else if (!ownerWants) begin
            mOwner[i] = -1;
          end
        end
      end
    end
  end

  // Every falling edge: all outputs of all instances against the model
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("gnt[%0d]", i), 32'(gntA[i]), 32'(ownerMask(mOwner[i])));
      checkOutput($sformatf("sel[%0d]", i), 32'(selA[i]),
                  32'((mOwner[i] >= 0) ? mOwner[i] : 0));
      checkOutput($sformatf("valid[%0d]", i), 32'(validA[i]), 32'(mValid[i]));
      checkOutput($sformatf("data[%0d]", i), 32'(dataA[i]), 32'(mData[i]));
    end
  end

  logic [3:0] vecTable [12] = '{4'b0110, 4'b0110, 4'b0011, 4'b1100, 4'b0101, 4'b1111,
                                4'b0000, 4'b1001, 4'b1000, 4'b0111, 4'b0010, 4'b0000};

  initial begin
    $display("[TB] start");
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset gnt", 32'(gntA[0]), 32'h0);
    checkOutput("reset valid", 32'(validA[0]), 32'h0);
    checkOutput("reset data", 32'(dataA[0]), 32'h0);
    rst_n = 1'b1;

    // Single requester after reset: grant, then data one cycle later
    applyStimulus(4'b0100, 1);
    checkOutput("first gnt", 32'(gntA[0]), 32'h4);
    checkOutput("first sel", 32'(selA[0]), 32'h2);
    checkOutput("first valid", 32'(validA[0]), 32'h0);
    applyStimulus(4'b0100, 1);
    checkOutput("first data valid", 32'(validA[0]), 32'h1);
    checkOutput("first data", 32'(dataA[0]), 32'hC3);

    // All requests drop: grant clears, then valid clears with data held
    applyStimulus(4'b0000, 1);
    checkOutput("drop gnt", 32'(gntA[0]), 32'h0);
    checkOutput("drop sel", 32'(selA[0]), 32'h0);
    applyStimulus(4'b0000, 1);
    checkOutput("drop valid", 32'(validA[0]), 32'h0);
    checkOutput("drop data held", 32'(dataA[0]), 32'hC3);

    // Fixed priority hand-over without an idle cycle
    applyStimulus(4'b1010, 1);
    checkOutput("fixed gnt low", 32'(gntA[1]), 32'h2);
    checkOutput("rr gnt after 2", 32'(gntA[0]), 32'h8);
    applyStimulus(4'b1000, 1);
    checkOutput("fixed handover", 32'(gntA[1]), 32'h8);
    checkOutput("fixed handover valid", 32'(validA[1]), 32'h1);
    applyStimulus(4'b0000, 2);

    // Everyone requesting: round-robin rotates every 4 cycles
    for (int k = 0; k < 20; k++) begin
      applyStimulus(4'b1111, 1);
      checkOutput($sformatf("rotate k=%0d", k), 32'(gntA[0]), 32'(4'b0001 << ((k / 4) % 4)));
    end
    applyStimulus(4'b0000, 2);

    // Sole requester holds indefinitely with continuous valid
    for (int k = 0; k < 40; k++) begin
      applyStimulus(4'b0001, 1);
      checkOutput($sformatf("sole gnt k=%0d", k), 32'(gntA[0]), 32'h1);
      if (k > 0) checkOutput($sformatf("sole valid k=%0d", k), 32'(validA[0]), 32'h1);
    end
    // Saturated hold counter: a newcomer preempts on the very next edge
    applyStimulus(4'b1001, 1);
    checkOutput("saturated preempt", 32'(gntA[0]), 32'h8);
    checkOutput("saturated preempt sel", 32'(selA[0]), 32'h3);
    applyStimulus(4'b0000, 2);

    // Asynchronous reset between edges while master 1 owns the bus
    applyStimulus(4'b0010, 2);
    checkOutput("pre-reset gnt", 32'(gntA[0]), 32'h2);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset gnt", 32'(gntA[0]), 32'h0);
    checkOutput("async reset valid", 32'(validA[0]), 32'h0);
    #1;
    rst_n = 1'b1;
    applyStimulus(4'b0010, 1);
    checkOutput("post-reset gnt", 32'(gntA[0]), 32'h2);
    checkOutput("post-reset fixed gnt", 32'(gntA[1]), 32'h2);

    // Mixed patterns with changing data, checked by the model
    for (int k = 0; k < 12; k++) begin
      dataIn = {8'(8'h40 + k), 8'(8'h30 + k), 8'(8'h20 + k), 8'(8'h10 + k)};
      applyStimulus(vecTable[k], 1);
    end
    applyStimulus(4'b0000, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/master_arbiter_mux.md
MASTER_ARBITER_MUX -- requirements
Module: master_arbiter_mux

Interface
REQ-001 Parameter NUM_MASTERS, default 4: number of requesting masters, legal range 2..16.
REQ-002 Parameter SEL_BITS, default 2: select width, SHALL satisfy 2^SEL_BITS >= NUM_MASTERS.
REQ-003 Parameter DATA_WIDTH, default 8: per-master data width.
REQ-004 Parameter ARB_MODE, default 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-005 Parameter HOLD_LIMIT, default 16: maximum consecutive grant cycles while another master requests; 0 disables preemption.
REQ-006 CLK  input  1  single clock; all state changes on rising edge.
REQ-007 RST_N  input  1  reset, asynchronous, active-low.
REQ-008 REQ  input  NUM_MASTERS  per-master bus request, bit i = master i.
REQ-009 DATA_IN  input  NUM_MASTERS*DATA_WIDTH  master i data at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 GNT  output  NUM_MASTERS  registered one-hot grant, all-zero when idle.
REQ-011 SEL  output  SEL_BITS  registered index of current owner; 0 when idle.
REQ-012 DATA_OUT  output  DATA_WIDTH  registered data of owner.
REQ-013 VALID  output  1  DATA_OUT qualifier.

Function
REQ-014 Two states SHALL exist: IDLE (no owner) and GRANT (one owner).
REQ-015 IDLE -> GRANT at an edge where any REQ bit is 1; winner chosen per REQ-018/019; GNT, SEL updated at the same edge.
REQ-016 GRANT, owner REQ still 1, no preemption: owner, GNT, SEL unchanged.
REQ-017 GRANT, owner REQ 0: at that edge, if any other REQ is 1 the next winner SHALL be granted directly (no idle cycle); otherwise -> IDLE, GNT all-zero, SEL 0.
REQ-018 Round-robin: search starts at index (last_owner+1) and wraps modulo NUM_MASTERS; first set REQ bit wins; last_owner updated on every new grant.
REQ-019 Fixed priority: lowest-indexed set REQ bit wins; last_owner still tracked but unused.
REQ-020 HOLD_CNT SHALL reset to 0 on every new grant, increment each GRANT cycle, saturate at HOLD_LIMIT-1.
REQ-021 With HOLD_LIMIT>0, at an edge where HOLD_CNT == HOLD_LIMIT-1 and any non-owner REQ is 1, grant SHALL move to the next winner (owner excluded from that search) regardless of owner REQ.
REQ-022 If only the owner requests, no preemption; grant held indefinitely, HOLD_CNT saturated.
REQ-023 At each edge where state is GRANT before update, DATA_OUT <= DATA_IN slice of current SEL and VALID <= 1; otherwise VALID <= 0 and DATA_OUT holds its value (one-cycle latency from GNT to VALID).
REQ-024 GNT SHALL never have more than one bit set; SEL SHALL always equal the index of the set GNT bit.
REQ-025 REQ bits at indices >= NUM_MASTERS do not exist; SEL values >= NUM_MASTERS SHALL never be produced.

Reset
REQ-026 RST_N low SHALL immediately force IDLE, GNT=0, SEL=0, DATA_OUT=0, VALID=0, HOLD_CNT=0, last_owner=NUM_MASTERS-1 (master 0 served first in round-robin).
REQ-027 Reset asserted mid-grant SHALL drop the grant asynchronously; first edge after release behaves as IDLE.

Verification
REQ-028 Defaults, RR: REQ=4'b0100 one edge after reset -> GNT=4'b0100, SEL=2; next edge VALID=1, DATA_OUT=DATA_IN[23:16].
REQ-029 RR, REQ=4'b1111 held, HOLD_LIMIT=4 -> grant order 0,1,2,3,0 each for exactly 4 cycles, no idle gaps.
REQ-030 Fixed mode, REQ=4'b1010 -> GNT=4'b0010; owner drops REQ to 4'b1000 -> GNT=4'b1000 next edge, no IDLE cycle.
REQ-031 Sole requester REQ=4'b0001 held 40 cycles, HOLD_LIMIT=4 -> GNT stays 4'b0001, VALID continuously 1 after first cycle.
REQ-032 All REQ drop during grant -> next edge GNT=0, SEL=0; following edge VALID=0, DATA_OUT unchanged.
REQ-033 RST_N pulsed low between edges while GNT=4'b0010 -> GNT=0, VALID=0 before next edge; after release REQ=4'b0010 -> GNT=4'b0010 one edge later.
